// File: rtl/hilo_mdu_if.sv
// hilo_mdu_if: issue/result bundle between the E-stage datapath and the HI/LO multiply/divide unit
//   startE      issue strobe (hlwriteE of a non-flushed E-stage instruction)
//   multordivE  0 = multiply, 1 = divide
//   signedE     1 = MULT/DIV, 0 = MULTU/DIVU
//   srcaE       rs operand: multiplicand or dividend
//   srcbE       rt operand: multiplier or divisor
//   busy        registered, high while an operation is in flight
//   hlbusy      busy | startE, stall request toward the hazard unit
//   hi, lo      architectural HI/LO registers
interface hilo_mdu_if #(parameter int WIDTH = 32);
    logic             startE;
    logic             multordivE;
    logic             signedE;
    logic [WIDTH-1:0] srcaE;
    logic [WIDTH-1:0] srcbE;
    logic             busy;
    logic             hlbusy;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output startE, multordivE, signedE, srcaE, srcbE,
        input  busy, hlbusy, hi, lo
    );

    modport slave (
        input  startE, multordivE, signedE, srcaE, srcbE,
        output busy, hlbusy, hi, lo
    );
endinterface

// File: rtl/hilo_mdu.sv
// hilo_mdu: iterative MULT/MULTU/DIV/DIVU unit holding the architectural HI/LO registers
//   clk    rising-edge clock
//   reset  asynchronous active-low reset
//   bus    hilo_mdu_if slave: issue strobe, op select, operands in; busy, hlbusy, hi, lo out
// One iteration per cycle for WIDTH cycles on operand magnitudes, then a single
// FIX cycle applies signs and writes HI/LO.
module hilo_mdu #(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     reset,
    hilo_mdu_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t             state, state_nxt;
    logic [CW-1:0]      cnt;
    logic               div, sgn, sign_a, sign_b, dz;
    logic [WIDTH-1:0]   opr, a_raw, hi_q, lo_q;
    logic [2*WIDTH-1:0] acc, acc_nxt, shl, prod;
    logic [WIDTH-1:0]   mag_a, mag_b, quo, rem;
    logic [WIDTH:0]     sum;
    logic [WIDTH+1:0]   diff;
    logic               busy, last, neg_res;

    assign busy       = state != IDLE;
    assign last       = cnt == CW'(WIDTH - 1);
    assign bus.busy   = busy;
    assign bus.hlbusy = busy | bus.startE;
    assign bus.hi     = hi_q;
    assign bus.lo     = lo_q;

    // Iterations run on magnitudes; signs are reapplied in FIX.
    assign mag_a = (bus.signedE && bus.srcaE[WIDTH-1]) ? -bus.srcaE : bus.srcaE;
    assign mag_b = (bus.signedE && bus.srcbE[WIDTH-1]) ? -bus.srcbE : bus.srcbE;

    always_comb begin
        state_nxt = (state == IDLE && bus.startE) ? RUN  :
                    (state == RUN && last)        ? FIX  :
                    (state == FIX)                ? IDLE : state;
    end

    // acc holds {P, multiplier} for multiply and {R, Q} for divide.
    // The divide trial subtract keeps the bit shifted out of R, since the
    // shifted remainder can reach WIDTH+1 bits before the subtraction.
    always_comb begin
        sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opr} : '0);
        shl     = {acc[2*WIDTH-2:0], 1'b0};
        diff    = {1'b0, acc[2*WIDTH-1], shl[2*WIDTH-1:WIDTH]} - {2'b0, opr};
        acc_nxt = div ? (diff[WIDTH+1] ? shl : {diff[WIDTH-1:0], shl[WIDTH-1:1], 1'b1})
                      : {sum, acc[WIDTH-1:1]};
        neg_res = sgn & (sign_a ^ sign_b);
        prod    = neg_res ? -acc : acc;
        quo     = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem     = (sgn & sign_a) ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt    <= '0;
            div    <= 1'b0;
            sgn    <= 1'b0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            dz     <= 1'b0;
            opr    <= '0;
            a_raw  <= '0;
            acc    <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else if (state == IDLE && bus.startE) begin
            cnt    <= '0;
            div    <= bus.multordivE;
            sgn    <= bus.signedE;
            sign_a <= bus.signedE & bus.srcaE[WIDTH-1];
            sign_b <= bus.signedE & bus.srcbE[WIDTH-1];
            dz     <= bus.srcbE == '0;
            a_raw  <= bus.srcaE;
            opr    <= bus.multordivE ? mag_b : mag_a;
            acc    <= {{WIDTH{1'b0}}, bus.multordivE ? mag_a : mag_b};
        end else if (state == RUN) begin
            cnt <= cnt + CW'(1);
            acc <= acc_nxt;
        end else if (state == FIX) begin
            // Divide by zero overrides the sign fixup: LO all ones, HI the raw dividend.
            hi_q <= !div ? prod[2*WIDTH-1:WIDTH] : dz ? a_raw : rem;
            lo_q <= !div ? prod[WIDTH-1:0] : dz ? '1 : quo;
        end
    end
endmodule

// File: tb/tb_hilo_mdu.sv
// tb_hilo_mdu: directed self-checking bench for hilo_mdu
module tb_hilo_mdu;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   vectors = 0;
    int   errors = 0;

    hilo_mdu_if #(.WIDTH(32)) bus ();

    hilo_mdu #(.WIDTH(32)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Issue one operation from #1 after an edge; returns hlbusy seen in the
    // start cycle and the number of cycles busy stayed high (bounded).
    task automatic issue(input logic d, input logic s, input logic [31:0] a, input logic [31:0] b,
                         output logic hlb, output int cyc);
        bus.startE = 1'b1;
        bus.multordivE = d;
        bus.signedE = s;
        bus.srcaE = a;
        bus.srcbE = b;
        #1 hlb = bus.hlbusy;
        @(posedge clk); #1;
        bus.startE = 1'b0;
        bus.srcaE = 32'h1234_5678;
        bus.srcbE = 32'h0;
        cyc = 0;
        while (bus.busy && cyc < 50) begin
            cyc++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        bus.startE = 1'b0;
        bus.multordivE = 1'b0;
        bus.signedE = 1'b0;
        bus.srcaE = '0;
        bus.srcbE = '0;
        #12;
        vectors++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        vectors++; if (bus.hlbusy !== 1'b0) begin errors++; $display("FAIL reset_hlbusy got=%b exp=0", bus.hlbusy); end
        vectors++; if (bus.hi !== 32'h0) begin errors++; $display("FAIL reset_hi got=%h exp=0", bus.hi); end
        vectors++; if (bus.lo !== 32'h0) begin errors++; $display("FAIL reset_lo got=%h exp=0", bus.lo); end
        #11 reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_mul_unsigned();
        logic hlb;
        int   cyc;
        issue(1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, hlb, cyc);
        vectors++; if (hlb !== 1'b1) begin errors++; $display("FAIL mulu_hlbusy_start got=%b exp=1", hlb); end
        vectors++; if (cyc !== 33) begin errors++; $display("FAIL mulu_busy_cycles got=%0d exp=33", cyc); end
        vectors++; if (bus.hi !== 32'hFFFF_FFFE) begin errors++; $display("FAIL mulu_hi got=%h exp=fffffffe", bus.hi); end
        vectors++; if (bus.lo !== 32'h0000_0001) begin errors++; $display("FAIL mulu_lo got=%h exp=00000001", bus.lo); end
    endtask

    task automatic test_mul_signed();
        logic hlb;
        int   cyc;
        issue(1'b0, 1'b1, 32'hFFFF_FFFD, 32'd7, hlb, cyc);
        vectors++; if (cyc !== 33) begin errors++; $display("FAIL mul_neg_cycles got=%0d exp=33", cyc); end
        vectors++; if (bus.hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mul_neg_hi got=%h exp=ffffffff", bus.hi); end
        vectors++; if (bus.lo !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mul_neg_lo got=%h exp=ffffffeb", bus.lo); end
        issue(1'b0, 1'b1, 32'h8000_0000, 32'h8000_0000, hlb, cyc);
        vectors++; if (bus.hi !== 32'h4000_0000) begin errors++; $display("FAIL mul_min_hi got=%h exp=40000000", bus.hi); end
        vectors++; if (bus.lo !== 32'h0) begin errors++; $display("FAIL mul_min_lo got=%h exp=00000000", bus.lo); end
    endtask

    task automatic test_div();
        logic hlb;
        int   cyc;
        issue(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, hlb, cyc);
        vectors++; if (cyc !== 33) begin errors++; $display("FAIL div_neg_cycles got=%0d exp=33", cyc); end
        vectors++; if (bus.lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_neg_lo got=%h exp=fffffffd", bus.lo); end
        vectors++; if (bus.hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_neg_hi got=%h exp=ffffffff", bus.hi); end
        issue(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, hlb, cyc);
        vectors++; if (bus.lo !== 32'h8000_0000) begin errors++; $display("FAIL div_ovf_lo got=%h exp=80000000", bus.lo); end
        vectors++; if (bus.hi !== 32'h0) begin errors++; $display("FAIL div_ovf_hi got=%h exp=00000000", bus.hi); end
        issue(1'b1, 1'b0, 32'd100, 32'd7, hlb, cyc);
        vectors++; if (bus.lo !== 32'd14) begin errors++; $display("FAIL divu_lo got=%h exp=0000000e", bus.lo); end
        vectors++; if (bus.hi !== 32'd2) begin errors++; $display("FAIL divu_hi got=%h exp=00000002", bus.hi); end
    endtask

    task automatic test_div_zero();
        logic hlb;
        int   cyc;
        issue(1'b1, 1'b0, 32'd100, 32'd0, hlb, cyc);
        vectors++; if (bus.lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divu0_lo got=%h exp=ffffffff", bus.lo); end
        vectors++; if (bus.hi !== 32'h0000_0064) begin errors++; $display("FAIL divu0_hi got=%h exp=00000064", bus.hi); end
        issue(1'b1, 1'b1, 32'hFFFF_FFFB, 32'd0, hlb, cyc);
        vectors++; if (bus.lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div0_lo got=%h exp=ffffffff", bus.lo); end
        vectors++; if (bus.hi !== 32'hFFFF_FFFB) begin errors++; $display("FAIL div0_hi got=%h exp=fffffffb", bus.hi); end
        repeat (5) @(posedge clk);
        #1;
        vectors++; if (bus.hi !== 32'hFFFF_FFFB) begin errors++; $display("FAIL hold_hi got=%h exp=fffffffb", bus.hi); end
        vectors++; if (bus.lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL hold_lo got=%h exp=ffffffff", bus.lo); end
    endtask

    task automatic test_start_busy();
        int cyc;
        bus.startE = 1'b1;
        bus.multordivE = 1'b0;
        bus.signedE = 1'b0;
        bus.srcaE = 32'd6;
        bus.srcbE = 32'd7;
        @(posedge clk); #1;
        bus.startE = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        bus.startE = 1'b1;
        bus.multordivE = 1'b1;
        bus.signedE = 1'b1;
        bus.srcaE = 32'd100;
        bus.srcbE = 32'd0;
        @(posedge clk); #1;
        bus.startE = 1'b0;
        vectors++; if (bus.hi !== 32'hFFFF_FFFB) begin errors++; $display("FAIL busy_hi_held got=%h exp=fffffffb", bus.hi); end
        cyc = 10;
        while (bus.busy && cyc < 60) begin
            cyc++;
            @(posedge clk); #1;
        end
        vectors++; if (cyc !== 33) begin errors++; $display("FAIL busy_not_extended got=%0d exp=33", cyc); end
        vectors++; if (bus.lo !== 32'd42) begin errors++; $display("FAIL busy_ignored_lo got=%h exp=0000002a", bus.lo); end
        vectors++; if (bus.hi !== 32'd0) begin errors++; $display("FAIL busy_ignored_hi got=%h exp=00000000", bus.hi); end
        repeat (3) @(posedge clk);
        #1;
        vectors++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL busy_no_restart got=%b exp=0", bus.busy); end
    endtask

    task automatic test_back_to_back();
        logic hlb;
        int   cyc;
        issue(1'b0, 1'b1, 32'hFFFF_FFFD, 32'd7, hlb, cyc);
        issue(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, hlb, cyc);
        vectors++; if (cyc !== 33) begin errors++; $display("FAIL b2b_cycles got=%0d exp=33", cyc); end
        vectors++; if (bus.lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL b2b_lo got=%h exp=fffffffd", bus.lo); end
        vectors++; if (bus.hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL b2b_hi got=%h exp=ffffffff", bus.hi); end
    endtask

    task automatic test_reset_mid();
        logic hlb;
        int   cyc;
        bus.startE = 1'b1;
        bus.multordivE = 1'b0;
        bus.signedE = 1'b0;
        bus.srcaE = 32'hFFFF_FFFF;
        bus.srcbE = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        bus.startE = 1'b0;
        repeat (14) @(posedge clk);
        #3 reset = 1'b0;
        #1;
        vectors++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got=%b exp=0", bus.busy); end
        vectors++; if (bus.hi !== 32'h0) begin errors++; $display("FAIL rst_mid_hi got=%h exp=00000000", bus.hi); end
        vectors++; if (bus.lo !== 32'h0) begin errors++; $display("FAIL rst_mid_lo got=%h exp=00000000", bus.lo); end
        @(posedge clk);
        #3 reset = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        vectors++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_after_busy got=%b exp=0", bus.busy); end
        vectors++; if (bus.hi !== 32'h0 || bus.lo !== 32'h0) begin errors++; $display("FAIL rst_no_write got=%h_%h exp=00000000_00000000", bus.hi, bus.lo); end
        issue(1'b0, 1'b0, 32'd6, 32'd7, hlb, cyc);
        vectors++; if (bus.lo !== 32'd42) begin errors++; $display("FAIL rst_fresh_lo got=%h exp=0000002a", bus.lo); end
        vectors++; if (bus.hi !== 32'd0) begin errors++; $display("FAIL rst_fresh_hi got=%h exp=00000000", bus.hi); end
    endtask

    initial begin
        test_reset();
        test_mul_unsigned();
        test_mul_signed();
        test_div();
        test_div_zero();
        test_start_busy();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/hilo_mdu.md
# hilo_mdu

Iterative multiply/divide unit with the architectural HI/LO registers for the pipelined MIPS core. It sits in the execute-stage datapath and consumes the E-stage `multordivE` and `hlwriteE` decode bits produced by the pipeline controller. It computes MULT/MULTU/DIV/DIVU over 32 iterations plus one sign-fixup cycle and holds the result in HI/LO for `mfhi`/`mflo`. It exports busy indications so the hazard unit can stall dependent HI/LO reads and new mult/div issues.

## Interface
Parameters:
- `WIDTH`, default 32, operand width; the iteration count equals `WIDTH`.

Ports:
- `clk`  input  1  rising-edge clock.
- `reset`  input  1  asynchronous, active-low reset.
- `startE`  input  1  issue strobe, driven by `hlwriteE` of a non-flushed E-stage instruction.
- `multordivE`  input  1  operation select: 0 = multiply, 1 = divide.
- `signedE`  input  1  1 = signed (MULT/DIV), 0 = unsigned (MULTU/DIVU).
- `srcaE`  input  WIDTH  rs operand: multiplicand or dividend.
- `srcbE`  input  WIDTH  rt operand: multiplier or divisor.
- `busy`  output  1  registered; high while an operation is in flight.
- `hlbusy`  output  1  combinational `busy | startE`, sent to the hazard unit to stall D-stage `mfhi`/`mflo` and mult/div.
- `hi`  output  WIDTH  HI register: product upper half, or remainder.
- `lo`  output  WIDTH  LO register: product lower half, or quotient.

## Operation
- States: IDLE, RUN, FIX. `busy = (state != IDLE)`.
- IDLE:
  - `startE=1` at a clock edge latches the operation, the sign flags, and the operand magnitudes.
  - Magnitudes are two's-complement absolute values when `signedE=1`, raw values otherwise.
  - Iteration counter clears; next state is RUN.
- RUN: one iteration per edge, counter increments; after iteration `WIDTH-1` the next state is FIX.
  - Multiply: radix-2 shift-add on a 2*WIDTH accumulator {P, multiplier}. If the multiplier LSB is 1, add the multiplicand to P with carry; then shift right by 1.
  - Divide: restoring division on {R, Q}. Shift left by 1, trial-subtract the divisor from R; if the result is non-negative, keep it and set the Q LSB, else restore.
- FIX: apply signs, write HI/LO, next state IDLE.
  - Multiply: negate the 2*WIDTH product if the operand signs differed (signed only).
  - Divide: negate the quotient if the signs differed; the remainder takes the dividend's sign (signed only).
  - Divisor == 0, any signedness: LO = all ones, HI = the original `srcaE` value. This overrides the sign fixup.
  - Signed 0x80000000 / -1: LO = 0x80000000, HI = 0 (natural wrap, no trap).
- `startE` while `busy` is ignored: no restart, and the in-flight operation is unaffected. The hazard unit guarantees this never happens in legal operation.
- HI/LO change only in FIX and during reset; they hold between operations.
- Operands are captured at the start edge; later changes on `srcaE`/`srcbE` have no effect.

## Timing
- Reset (`reset=0`, asynchronous):
  - state = IDLE, `busy` = 0, `hi` = 0, `lo` = 0, counter = 0.
  - Any in-flight operation is aborted and not written.
  - Reset release is sampled at the next edge; no operation starts before then.
- Start accepted at edge T0:
  - `busy` rises after T0.
  - RUN edges are T0+1 .. T0+WIDTH.
  - FIX edge is T0+WIDTH+1, which writes HI/LO and drops `busy`.
  - Latency is WIDTH+1 = 33 cycles from the start edge to new HI/LO.
- Back-to-back: a new `startE` is accepted on the first edge with `busy=0`, i.e. T0+WIDTH+2 at the earliest.
- `hlbusy` is high in the start cycle itself (via `startE`) and in every busy cycle. This covers an `mfhi`/`mflo` in D directly behind the mult/div in E.
- `hi`/`lo` are registered outputs with no combinational path from the inputs.

## Test plan
- Unsigned multiply: `startE=1`, `multordivE=0`, `signedE=0`, 0xFFFFFFFF × 0xFFFFFFFF -> after 33 cycles HI=0xFFFFFFFE, LO=0x00000001; `busy` high exactly 33 cycles; `hlbusy` high in the start cycle.
- Signed multiply: -3 × 7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB.
  - Then 0x80000000 × 0x80000000 signed -> HI=0x40000000, LO=0.
- Signed divide:
  - -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
  - Unsigned 100 / 7 -> LO=14, HI=2.
- Divide by zero: 100 / 0 unsigned -> LO=0xFFFFFFFF, HI=0x00000064.
  - Signed -5 / 0 -> LO=0xFFFFFFFF, HI=0xFFFFFFFB.
- Start while busy: a second `startE` with different operands at cycle T0+10 -> ignored; first result unchanged at T0+33; `busy` not extended.
- Reset mid-operation: assert `reset=0` at cycle T0+15 -> `busy`, `hi`, `lo` go to 0 immediately, with no later write.
  - After release, a fresh 6 × 7 gives LO=42, HI=0.
